// File: rtl/mips_ctrl_pkg.sv
// Control encodings shared by the multicycle MIPS datapath, main control FSM and ALU control decoder.
package mips_ctrl_pkg;
    localparam int OP_W    = 6;
    localparam int STATE_W = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    localparam logic [OP_W-1:0] ALUOP_ADD   = 6'b001000;
    localparam logic [OP_W-1:0] ALUOP_RTYPE = 6'b000000;

    typedef enum logic [STATE_W-1:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EX_R    = 4'd3,
        S_EX_I    = 4'd4,
        S_EX_ADDR = 4'd5,
        S_EX_BR   = 4'd6,
        S_EX_J    = 4'd7,
        S_EX_JAL  = 4'd8,
        S_MEM_RD  = 4'd9,
        S_MEM_WR  = 4'd10,
        S_WB_R    = 4'd11,
        S_WB_I    = 4'd12,
        S_WB_MEM  = 4'd13,
        S_TRAP    = 4'd14
    } state_t;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_REGA   = 2'd3;

    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    localparam logic [1:0] MEM_TO_REG_ALUOUT = 2'd0;
    localparam logic [1:0] MEM_TO_REG_MDR    = 2'd1;
    localparam logic [1:0] MEM_TO_REG_PC     = 2'd2;

    localparam logic [1:0] ALU_SRC_B_B      = 2'd0;
    localparam logic [1:0] ALU_SRC_B_FOUR   = 2'd1;
    localparam logic [1:0] ALU_SRC_B_IMM    = 2'd2;
    localparam logic [1:0] ALU_SRC_B_IMM_SH = 2'd3;

    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_R       = 4'd1,
        CLS_I       = 4'd2,
        CLS_LW      = 4'd3,
        CLS_SW      = 4'd4,
        CLS_BEQ     = 4'd5,
        CLS_BNE     = 4'd6,
        CLS_J       = 4'd7,
        CLS_JAL     = 4'd8
    } op_class_t;
endpackage

// File: rtl/mc_opcode_class.sv
// Combinational opcode -> instruction-class decode used by the main control FSM.
module mc_opcode_class
    import mips_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] opcode_i,
    output op_class_t       op_class_o
);

    // Map each supported opcode to its class; anything else is illegal
    always_comb begin
        case (opcode_i)
            OP_RTYPE:                      op_class_o = CLS_R;
            OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: op_class_o = CLS_I;
            OP_LW:                         op_class_o = CLS_LW;
            OP_SW:                         op_class_o = CLS_SW;
            OP_BEQ:                        op_class_o = CLS_BEQ;
            OP_BNE:                        op_class_o = CLS_BNE;
            OP_J:                          op_class_o = CLS_J;
            OP_JAL:                        op_class_o = CLS_JAL;
            default:                       op_class_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multicycle MIPS core. Define ILLEGAL_TRAP_EN to halt in S_TRAP
// (with illegal_op output) on an illegal opcode instead of treating it as a NOP.
module multicycle_main_control
    import mips_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    input  logic            jr_flag,
    input  logic            mem_ready,
    output logic [OP_W-1:0] alu_op,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic            i_or_d,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic            reg_write,
    output logic            pc_write,
    output logic [1:0]      pc_src,
    output logic [1:0]      reg_dst,
    output logic [1:0]      mem_to_reg,
    output logic            instr_done
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic            illegal_op
`endif
);

    state_t    state_q;
    state_t    state_d;
    op_class_t op_class_s;

    mc_opcode_class u_opcode_class (
        .opcode_i   (opcode),
        .op_class_o (op_class_s)
    );

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
                else           state_d = S_FETCH;
            end
            S_DECODE: begin
                case (op_class_s)
                    CLS_R:          state_d = S_EX_R;
                    CLS_I:          state_d = S_EX_I;
                    CLS_LW, CLS_SW: state_d = S_EX_ADDR;
                    CLS_BEQ, CLS_BNE: state_d = S_EX_BR;
                    CLS_J:          state_d = S_EX_J;
                    CLS_JAL:        state_d = S_EX_JAL;
`ifdef ILLEGAL_TRAP_EN
                    default:        state_d = S_TRAP;
`else
                    default:        state_d = S_FETCH;
`endif
                endcase
            end
            S_EX_R: begin
                if (jr_flag) state_d = S_FETCH;
                else         state_d = S_WB_R;
            end
            S_EX_I:   state_d = S_WB_I;
            S_EX_ADDR: begin
                if (op_class_s == CLS_LW) state_d = S_MEM_RD;
                else                      state_d = S_MEM_WR;
            end
            S_EX_BR, S_EX_J, S_EX_JAL: state_d = S_FETCH;
            S_MEM_RD: begin
                if (mem_ready) state_d = S_WB_MEM;
                else           state_d = S_MEM_RD;
            end
            S_MEM_WR: begin
                if (mem_ready) state_d = S_FETCH;
                else           state_d = S_MEM_WR;
            end
            S_WB_R, S_WB_I, S_WB_MEM: state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:   state_d = S_TRAP;
`endif
            default:  state_d = S_RESET;
        endcase
    end

    // State register; reset clears it immediately so every output drops without a clock edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_RESET;
        else        state_q <= state_d;
    end

    // Moore decode of state, plus the input-qualified pc_write/ir_write/instr_done
    always_comb begin
        alu_op     = ALUOP_RTYPE;
        alu_src_a  = 1'b0;
        alu_src_b  = ALU_SRC_B_B;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_ALU;
        reg_dst    = REG_DST_RT;
        mem_to_reg = MEM_TO_REG_ALUOUT;
        instr_done = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ALU_SRC_B_FOUR;
                alu_op    = ALUOP_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = ALU_SRC_B_IMM_SH;
                alu_op    = ALUOP_ADD;
`ifdef ILLEGAL_TRAP_EN
                instr_done = 1'b0;
`else
                instr_done = (op_class_s == CLS_ILLEGAL);
`endif
            end
            S_EX_R: begin
                alu_src_a = 1'b1;
                if (jr_flag) begin
                    pc_write   = 1'b1;
                    pc_src     = PC_SRC_REGA;
                    instr_done = 1'b1;
                end else begin
                    pc_write   = 1'b0;
                end
            end
            S_EX_I, S_EX_ADDR: begin
                alu_op    = opcode;
                alu_src_a = 1'b1;
                alu_src_b = ALU_SRC_B_IMM;
            end
            S_EX_BR: begin
                alu_op     = opcode;
                alu_src_a  = 1'b1;
                pc_src     = PC_SRC_ALUOUT;
                pc_write   = (op_class_s == CLS_BNE) ? ~zero : zero;
                instr_done = 1'b1;
            end
            S_EX_J: begin
                pc_write   = 1'b1;
                pc_src     = PC_SRC_JUMP;
                instr_done = 1'b1;
            end
            S_EX_JAL: begin
                pc_write   = 1'b1;
                pc_src     = PC_SRC_JUMP;
                reg_write  = 1'b1;
                reg_dst    = REG_DST_RA;
                mem_to_reg = MEM_TO_REG_PC;
                instr_done = 1'b1;
            end
            S_MEM_RD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
            end
            S_MEM_WR: begin
                i_or_d     = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ready;
            end
            S_WB_R: begin
                reg_write  = 1'b1;
                reg_dst    = REG_DST_RD;
                instr_done = 1'b1;
            end
            S_WB_I: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = MEM_TO_REG_MDR;
                instr_done = 1'b1;
            end
            default: begin
                instr_done = 1'b0;
            end
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    assign illegal_op = (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench for multicycle_main_control: per-cycle expected control vectors are queued
// with the stimulus and compared at the falling edge.
module tb_multicycle_main_control;

    typedef struct packed {
        logic [5:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       instr_done;
    } out_t;

    typedef struct packed {
        logic [5:0] op;
        logic       zero;
        logic       jr;
        logic       rdy;
    } stim_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       jr_flag = 1'b0;
    logic       mem_ready = 1'b0;
    logic [5:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       i_or_d, mem_read, mem_write, ir_write, reg_write, pc_write, instr_done;
    logic [1:0] pc_src, reg_dst, mem_to_reg;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    out_t  obs_s;
    stim_t stim_q[$];
    out_t  sb_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    multicycle_main_control dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .jr_flag    (jr_flag),
        .mem_ready  (mem_ready),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .instr_done (instr_done)
`ifdef ILLEGAL_TRAP_EN
        ,
        .illegal_op (illegal_op)
`endif
    );

    assign obs_s = {alu_op, alu_src_a, alu_src_b, i_or_d, mem_read, mem_write, ir_write,
                    reg_write, pc_write, pc_src, reg_dst, mem_to_reg, instr_done};

    function automatic out_t eo(input logic [5:0] op, input logic sa, input logic [1:0] sb,
                                input logic iord, input logic mr, input logic mw, input logic irw,
                                input logic rw, input logic pcw, input logic [1:0] pcs,
                                input logic [1:0] rd, input logic [1:0] m2r, input logic dn);
        return {op, sa, sb, iord, mr, mw, irw, rw, pcw, pcs, rd, m2r, dn};
    endfunction

    // Expected vectors for each control step, written from the state table
    function automatic out_t fetch_e(input logic r);
        return eo(6'b001000, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, r, 1'b0, r, 2'd0, 2'd0, 2'd0, 1'b0);
    endfunction
    function automatic out_t dec_e(input logic d);
        return eo(6'b001000, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, d);
    endfunction
    function automatic out_t exr_e(input logic jr);
        return eo(6'b000000, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, jr, jr ? 2'd3 : 2'd0, 2'd0, 2'd0, jr);
    endfunction
    function automatic out_t exi_e(input logic [5:0] op);
        return eo(op, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
    endfunction
    function automatic out_t exbr_e(input logic [5:0] op, input logic pcw);
        return eo(op, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pcw, 2'd1, 2'd0, 2'd0, 1'b1);
    endfunction
    function automatic out_t memrd_e();
        return eo(6'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
    endfunction
    function automatic out_t memwr_e(input logic r);
        return eo(6'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, r);
    endfunction
    function automatic out_t wb_e(input logic [1:0] rd, input logic [1:0] m2r);
        return eo(6'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, rd, m2r, 1'b1);
    endfunction
    function automatic out_t exj_e(input logic link);
        return eo(6'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, link, 1'b1, 2'd2,
                  link ? 2'd2 : 2'd0, link ? 2'd2 : 2'd0, 1'b1);
    endfunction

    task automatic push(input logic [5:0] op, input logic z, input logic jr, input logic r, input out_t e);
        stim_q.push_back({op, z, jr, r});
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        stim_t s;
        out_t  e;
        int    cyc = 0;
        reset = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_s !== 22'd0) begin
            errors++; $display("FAIL reset_hold: got %h expected %h", obs_s, 22'd0);
        end
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        checks++;
        if (obs_s !== 22'd0) begin
            errors++; $display("FAIL reset_state: got %h expected %h", obs_s, 22'd0);
        end
        push(6'b000010, 1'b0, 1'b0, 1'b0, fetch_e(1'b0));
        push(6'b000010, 1'b0, 1'b0, 1'b1, fetch_e(1'b1));
        push(6'b000010, 1'b0, 1'b0, 1'b1, dec_e(1'b0));
        push(6'b000010, 1'b0, 1'b0, 1'b1, exj_e(1'b0));
        while (stim_q.size() > 0) begin
            @(posedge clk); #1;
            s = stim_q.pop_front();
            {opcode, zero, jr_flag, mem_ready} = s;
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (obs_s !== e) begin
                errors++; $display("FAIL first_fetch cyc%0d: got %h expected %h", cyc, obs_s, e);
            end
            cyc++;
        end
    endtask

    task automatic test_add();
        stim_t s;
        out_t  e;
        int    cyc = 0;
        push(6'b000000, 1'b0, 1'b0, 1'b1, fetch_e(1'b1));
        push(6'b000000, 1'b0, 1'b0, 1'b1, dec_e(1'b0));
        push(6'b000000, 1'b0, 1'b0, 1'b1, exr_e(1'b0));
        push(6'b000000, 1'b0, 1'b0, 1'b1, wb_e(2'd1, 2'd0));
        while (stim_q.size() > 0) begin
            @(posedge clk); #1;
            s = stim_q.pop_front();
            {opcode, zero, jr_flag, mem_ready} = s;
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (obs_s !== e) begin
                errors++; $display("FAIL add cyc%0d: got %h expected %h", cyc, obs_s, e);
            end
            cyc++;
        end
    endtask

    task automatic test_itype();
        stim_t s;
        out_t  e;
        int    cyc = 0;
        // mem_ready low outside memory states must not stall
        push(6'b001101, 1'b0, 1'b0, 1'b1, fetch_e(1'b1));
        push(6'b001101, 1'b0, 1'b0, 1'b0, dec_e(1'b0));
        push(6'b001101, 1'b0, 1'b0, 1'b0, exi_e(6'b001101));
        push(6'b001101, 1'b0, 1'b0, 1'b0, wb_e(2'd0, 2'd0));
        while (stim_q.size() > 0) begin
            @(posedge clk); #1;
            s = stim_q.pop_front();
            {opcode, zero, jr_flag, mem_ready} = s;
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (obs_s !== e) begin
                errors++; $display("FAIL ori cyc%0d: got %h expected %h", cyc, obs_s, e);
            end
            cyc++;
        end
    endtask

    task automatic test_mem();
        stim_t s;
        out_t  e;
        int    cyc = 0;
        push(6'b100011, 1'b0, 1'b0, 1'b1, fetch_e(1'b1));
        push(6'b100011, 1'b0, 1'b0, 1'b1, dec_e(1'b0));
        push(6'b100011, 1'b0, 1'b0, 1'b1, exi_e(6'b100011));
        push(6'b100011, 1'b0, 1'b0, 1'b0, memrd_e());
        push(6'b100011, 1'b0, 1'b0, 1'b0, memrd_e());
        push(6'b100011, 1'b0, 1'b0, 1'b1, memrd_e());
        push(6'b100011, 1'b0, 1'b0, 1'b1, wb_e(2'd0, 2'd1));
        push(6'b101011, 1'b0, 1'b0, 1'b0, fetch_e(1'b0));
        push(6'b101011, 1'b0, 1'b0, 1'b1, fetch_e(1'b1));
        push(6'b101011, 1'b0, 1'b0, 1'b1, dec_e(1'b0));
        push(6'b101011, 1'b0, 1'b0, 1'b1, exi_e(6'b101011));
        push(6'b101011, 1'b0, 1'b0, 1'b0, memwr_e(1'b0));
        push(6'b101011, 1'b0, 1'b0, 1'b1, memwr_e(1'b1));
        while (stim_q.size() > 0) begin
            @(posedge clk); #1;
            s = stim_q.pop_front();
            {opcode, zero, jr_flag, mem_ready} = s;
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (obs_s !== e) begin
                errors++; $display("FAIL lw_sw cyc%0d: got %h expected %h", cyc, obs_s, e);
            end
            if (mem_read === 1'b1 && mem_write === 1'b1) begin
                errors++; $display("FAIL rw_exclusive cyc%0d: got 1/1 expected not both", cyc);
            end
            cyc++;
        end
    endtask

    task automatic test_branch();
        stim_t      s;
        out_t       e;
        int         cyc = 0;
        logic [5:0] op;
        for (int i = 0; i < 4; i++) begin
            op = (i % 2 == 0) ? 6'b000100 : 6'b000101;
            push(op, i < 2, 1'b0, 1'b1, fetch_e(1'b1));
            push(op, i < 2, 1'b0, 1'b1, dec_e(1'b0));
            push(op, i < 2, 1'b0, 1'b1, exbr_e(op, (i == 0) || (i == 3)));
        end
        while (stim_q.size() > 0) begin
            @(posedge clk); #1;
            s = stim_q.pop_front();
            {opcode, zero, jr_flag, mem_ready} = s;
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (obs_s !== e) begin
                errors++; $display("FAIL branch cyc%0d: got %h expected %h", cyc, obs_s, e);
            end
            cyc++;
        end
    endtask

    task automatic test_jumps();
        stim_t s;
        out_t  e;
        int    cyc = 0;
        push(6'b000000, 1'b0, 1'b1, 1'b1, fetch_e(1'b1));
        push(6'b000000, 1'b0, 1'b1, 1'b1, dec_e(1'b0));
        push(6'b000000, 1'b0, 1'b1, 1'b1, exr_e(1'b1));
        push(6'b000011, 1'b0, 1'b0, 1'b1, fetch_e(1'b1));
        push(6'b000011, 1'b0, 1'b0, 1'b1, dec_e(1'b0));
        push(6'b000011, 1'b0, 1'b0, 1'b1, exj_e(1'b1));
        while (stim_q.size() > 0) begin
            @(posedge clk); #1;
            s = stim_q.pop_front();
            {opcode, zero, jr_flag, mem_ready} = s;
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (obs_s !== e) begin
                errors++; $display("FAIL jr_jal cyc%0d: got %h expected %h", cyc, obs_s, e);
            end
            cyc++;
        end
    endtask

    task automatic test_back_to_back();
        stim_t s;
        out_t  e;
        int    cyc = 0;
        push(6'b001000, 1'b0, 1'b0, 1'b1, fetch_e(1'b1));
        push(6'b001000, 1'b1, 1'b1, 1'($urandom_range(0, 1)), dec_e(1'b0));
        push(6'b001000, 1'b1, 1'b1, 1'($urandom_range(0, 1)), exi_e(6'b001000));
        push(6'b001000, 1'b1, 1'b1, 1'($urandom_range(0, 1)), wb_e(2'd0, 2'd0));
        push(6'b000010, 1'b0, 1'b0, 1'b1, fetch_e(1'b1));
        push(6'b000010, 1'b0, 1'b0, 1'($urandom_range(0, 1)), dec_e(1'b0));
        push(6'b000010, 1'b0, 1'b0, 1'($urandom_range(0, 1)), exj_e(1'b0));
        push(6'b001111, 1'b0, 1'b0, 1'b1, fetch_e(1'b1));
        push(6'b001111, 1'b0, 1'b0, 1'b1, dec_e(1'b0));
        push(6'b001111, 1'b0, 1'b0, 1'b1, exi_e(6'b001111));
        push(6'b001111, 1'b0, 1'b0, 1'b1, wb_e(2'd0, 2'd0));
        while (stim_q.size() > 0) begin
            @(posedge clk); #1;
            s = stim_q.pop_front();
            {opcode, zero, jr_flag, mem_ready} = s;
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (obs_s !== e) begin
                errors++; $display("FAIL b2b cyc%0d: got %h expected %h", cyc, obs_s, e);
            end
            cyc++;
        end
    endtask

    task automatic test_reset_mid_mem();
        stim_t s;
        out_t  e;
        int    cyc = 0;
        push(6'b100011, 1'b0, 1'b0, 1'b1, fetch_e(1'b1));
        push(6'b100011, 1'b0, 1'b0, 1'b1, dec_e(1'b0));
        push(6'b100011, 1'b0, 1'b0, 1'b1, exi_e(6'b100011));
        push(6'b100011, 1'b0, 1'b0, 1'b0, memrd_e());
        while (stim_q.size() > 0) begin
            @(posedge clk); #1;
            s = stim_q.pop_front();
            {opcode, zero, jr_flag, mem_ready} = s;
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (obs_s !== e) begin
                errors++; $display("FAIL mid_reset_pre cyc%0d: got %h expected %h", cyc, obs_s, e);
            end
            cyc++;
        end
        // Drop reset between edges: outputs must clear before any clock edge
        #1 reset = 1'b0;
        #1;
        checks++;
        if (obs_s !== 22'd0) begin
            errors++; $display("FAIL mid_reset_async: got %h expected %h", obs_s, 22'd0);
        end
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        checks++;
        if (obs_s !== 22'd0) begin
            errors++; $display("FAIL mid_reset_sreset: got %h expected %h", obs_s, 22'd0);
        end
    endtask

    task automatic test_illegal();
        stim_t s;
        out_t  e;
        int    cyc = 0;
        push(6'b111111, 1'b0, 1'b0, 1'b1, fetch_e(1'b1));
`ifdef ILLEGAL_TRAP_EN
        push(6'b111111, 1'b0, 1'b0, 1'b1, dec_e(1'b0));
        for (int i = 0; i < 4; i++) push(6'b111111, 1'b0, 1'b0, 1'b1, 22'd0);
`else
        push(6'b111111, 1'b0, 1'b0, 1'b1, dec_e(1'b1));
        push(6'b000000, 1'b0, 1'b0, 1'b1, fetch_e(1'b1));
`endif
        while (stim_q.size() > 0) begin
            @(posedge clk); #1;
            s = stim_q.pop_front();
            {opcode, zero, jr_flag, mem_ready} = s;
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (obs_s !== e) begin
                errors++; $display("FAIL illegal cyc%0d: got %h expected %h", cyc, obs_s, e);
            end
`ifdef ILLEGAL_TRAP_EN
            checks++;
            if (illegal_op !== (cyc >= 2)) begin
                errors++; $display("FAIL illegal_op cyc%0d: got %b expected %b", cyc, illegal_op, cyc >= 2);
            end
`endif
            cyc++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_itype();
        test_mem();
        test_branch();
        test_jumps();
        test_back_to_back();
        test_reset_mid_mem();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
